sfft_frame_reader: RTL and testbench
====================================

# sfft_frame_reader

Consumer end of the SFFT pipeline's output interface. Captures each completed spectrum frame presented on the pipeline's parallel output bus (qualified by the one-cycle OutputValid pulse) into a two-frame ping-pong buffer. Streams the bins out one per clock on a valid/ready interface toward the peak-finding/fingerprint logic. Frames that arrive while both buffers are occupied are dropped and counted.

## Interface
- NFFT, 512, points per frame on the input bus; power of 2, ≥4
- DATA_WIDTH, 32, width of each bin; matches the SFFT output width
- BINS_OUT, NFFT/2, bins streamed per frame: indices 0..BINS_OUT-1, since only the lower half is meaningful for real input; 2 ≤ BINS_OUT ≤ NFFT
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- SFFT_Out  in  DATA_WIDTH × NFFT  unpacked array of frame bins from the pipeline
- OutputValid  in  1  frame-complete strobe from the pipeline
- outData  out  DATA_WIDTH  current bin value
- outBinIndex  out  log2(NFFT)  index of the current bin
- outValid  out  1  outData/outBinIndex/outFirst/outLast valid
- outReady  in  1  downstream accepts the beat when high with outValid
- outFirst  out  1  beat is bin 0
- outLast  out  1  beat is bin BINS_OUT-1
- framesDropped  out  16  saturating count of dropped frames
- bufferFull  out  1  both banks hold unread frames

## Operation
- Two banks, each BINS_OUT × DATA_WIDTH, plus per-bank full flag. wrPtr, rdPtr are 1-bit.
- Capture event: rising edge of OutputValid, i.e. OutputValid=1 with the previous-cycle registered value 0. A level held high captures once.
- On a capture event:
  - If bank[wrPtr] is free, copy SFFT_Out[0..BINS_OUT-1] into it, set its full flag, and toggle wrPtr.
  - If bank[wrPtr] is full, discard the frame and increment framesDropped, saturating at 0xFFFF.
- A bank being released in the same cycle counts as free: capture proceeds into it, and its full flag stays 1.
- Read FSM:
  - IDLE: outValid=0. If bank[rdPtr] is full, go to STREAM with binIdx=0.
  - STREAM: outValid=1, outData=bank[rdPtr][binIdx], outBinIndex=binIdx, outFirst=(binIdx==0), outLast=(binIdx==BINS_OUT-1).
    - On outValid&&outReady with binIdx<BINS_OUT-1: binIdx+1.
    - On outValid&&outReady with outLast: clear full[rdPtr] (unless a simultaneous capture refills it), toggle rdPtr, go to IDLE.
  - Without outReady, all outputs hold stable.
- Frames are delivered strictly in capture order; no partial frames are ever emitted.
- bufferFull = full[0]&&full[1].
- All outputs are registered or decoded from registered state. outData is a registered-address bank read and must be valid in the same cycle as outValid.

## Timing
- Reset values: outValid=0, outFirst=0, outLast=0, outData=0, outBinIndex=0, framesDropped=0, bufferFull=0, both full flags 0, wrPtr=rdPtr=0, FSM=IDLE, edge-detect register=0. Bank contents are don't-care.
- Reset mid-stream abandons the frame in flight and all buffered frames. The first beat after reset can only come from a frame captured after reset.
- Latency: with OutputValid rising in cycle T and both banks empty, full is set at T+1 and outValid is first asserted at T+2 with bin 0.
- Throughput: one bin per cycle while outReady=1. There is one IDLE bubble cycle between consecutive frames, so a frame occupies BINS_OUT+1 cycles minimum.
- Capture on the same cycle as the last beat into the releasing bank:
  - the outgoing last beat still carries the old data;
  - the new frame is streamed after the IDLE cycle.
- Drop decision uses the state at the capture cycle. A drop and a release in the same cycle for different banks: the drop stands.

## Test plan
- NFFT=8, BINS_OUT=4; frame bins = 10,11,12,13,…; one OutputValid pulse at cycle 5, outReady=1 → beats at cycles 7–10 with outData 10,11,12,13 and outBinIndex 0–3, outFirst at cycle 7, outLast at cycle 10, then outValid=0.
- Same stimulus, OutputValid held high 3 cycles → exactly one frame streamed, framesDropped=0.
- outReady=0 for cycles 7–9, then 1 → outData=10 held stable with outValid=1 through cycle 9; remaining beats at 10–13, no bins skipped or repeated.
- outReady=0 throughout; three frames A, B, C pulsed 20 cycles apart → A and B buffered, bufferFull=1, C dropped, framesDropped=1. Release outReady → A then B delivered in order; then C′ captured and delivered.
- Capture of frame B timed on the same cycle as frame A's outLast handshake with the other bank full → old last beat correct, B not dropped, subsequent order correct.
- Assert reset at bin 2 of a stream with the second bank full → next cycle outValid=0 and framesDropped=0. No output until a new OutputValid pulse, whose frame streams from bin 0.

Source files
------------

// File: rtl/sfft_frame_reader_if.sv
// Bundle between the SFFT pipeline output bus, the frame reader and the
// downstream bin consumer.
interface sfft_frame_reader_if #(
  parameter int NFFT       = 512,
  parameter int DATA_WIDTH = 32
);
  localparam int IW = $clog2(NFFT);

  logic [DATA_WIDTH-1:0] SFFT_Out [NFFT];
  logic                  OutputValid;
  logic [DATA_WIDTH-1:0] outData;
  logic [IW-1:0]         outBinIndex;
  logic                  outValid;
  logic                  outReady;
  logic                  outFirst;
  logic                  outLast;
  logic [15:0]           framesDropped;
  logic                  bufferFull;

  modport slave (
    input  SFFT_Out, OutputValid, outReady,
    output outData, outBinIndex, outValid, outFirst, outLast,
           framesDropped, bufferFull
  );

  modport master (
    output SFFT_Out, OutputValid, outReady,
    input  outData, outBinIndex, outValid, outFirst, outLast,
           framesDropped, bufferFull
  );
endinterface

// File: rtl/sfft_frame_reader.sv
// Captures SFFT output frames into a ping-pong buffer and streams the lower
// BINS_OUT bins one per clock over a valid/ready interface.
module sfft_frame_reader #(
  parameter int NFFT       = 512,
  parameter int DATA_WIDTH = 32,
  parameter int BINS_OUT   = NFFT / 2
) (
  input  logic               clk,
  input  logic               reset,
  sfft_frame_reader_if.slave bus
);
  localparam int IW = $clog2(NFFT);
  localparam int AW = (BINS_OUT > 1) ? $clog2(BINS_OUT) : 1;

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t                r_state, w_state_nx;
  logic [IW-1:0]         r_bin, w_bin_nx;
  logic [1:0]            r_full, w_full_nx;
  logic                  r_wr, r_rd, r_ov_d;
  logic [15:0]           r_drop;
  logic [DATA_WIDTH-1:0] r_bank [2][BINS_OUT];

  logic                  w_cap, w_last, w_rel, w_free, w_wr_en, w_drop, w_stream;
  logic [AW-1:0]         w_raddr;

  assign w_cap    = bus.OutputValid & ~r_ov_d;
  assign w_last   = (r_bin == IW'(BINS_OUT - 1));
  assign w_stream = (r_state == S_STREAM);
  // A bank handing off its last beat this cycle may be refilled immediately.
  assign w_free   = ~r_full[r_wr] | (w_rel & (r_rd == r_wr));
  assign w_wr_en  = w_cap & w_free;
  assign w_drop   = w_cap & ~w_free;
  assign w_raddr  = r_bin[AW-1:0];

  always_comb begin
    w_state_nx = r_state;
    w_bin_nx   = r_bin;
    w_rel      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_full[r_rd]) begin
          w_state_nx = S_STREAM;
          w_bin_nx   = '0;
        end
      end
      S_STREAM: begin
        if (bus.outReady) begin
          if (w_last) begin
            w_rel      = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            w_bin_nx = r_bin + 1'b1;
          end
        end
      end
    endcase
  end

  // Set wins over clear so a same-cycle refill keeps the bank marked full.
  always_comb begin
    w_full_nx = r_full;
    if (w_rel)   w_full_nx[r_rd] = 1'b0;
    if (w_wr_en) w_full_nx[r_wr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_bin   <= '0;
      r_full  <= '0;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_ov_d  <= 1'b0;
      r_drop  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_bin   <= w_bin_nx;
      r_full  <= w_full_nx;
      r_ov_d  <= bus.OutputValid;
      if (w_rel)   r_rd <= ~r_rd;
      if (w_wr_en) r_wr <= ~r_wr;
      if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < BINS_OUT; i++) r_bank[r_wr][i] <= bus.SFFT_Out[i];
    end
  end

  assign bus.outValid      = w_stream;
  assign bus.outData       = w_stream ? r_bank[r_rd][w_raddr] : '0;
  assign bus.outBinIndex   = w_stream ? r_bin : '0;
  assign bus.outFirst      = w_stream & (r_bin == '0);
  assign bus.outLast       = w_stream & w_last;
  assign bus.framesDropped = r_drop;
  assign bus.bufferFull    = &r_full;
endmodule

// File: tb/tb_sfft_frame_reader.sv
// Directed and random checks of sfft_frame_reader against a frame-queue model.
module tb_sfft_frame_reader;
  localparam int NFFT = 8;
  localparam int DW   = 32;
  localparam int BO   = 4;
  localparam int IW   = $clog2(NFFT);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sfft_frame_reader_if #(.NFFT(NFFT), .DATA_WIDTH(DW)) bus ();

  sfft_frame_reader #(.NFFT(NFFT), .DATA_WIDTH(DW), .BINS_OUT(BO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef logic [DW-1:0] frame_t [BO];

  int     total = 0;
  int     bad   = 0;
  frame_t q[$];
  int     mdrop, mbin, n_beats, b0;
  bit     mprev;
  logic          o_v, o_f, o_l, o_bf;
  logic [DW-1:0] o_d;
  logic [IW-1:0] o_i;
  logic [15:0]   o_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_frame(input int base);
    for (int i = 0; i < NFFT; i++) bus.SFFT_Out[i] = DW'(base + i);
  endtask

  // One clock: sample at negedge, score against the model, update the model
  // with the inputs the DUT is about to see, then move past the edge.
  task automatic step();
    bit     rel;
    bit     cap;
    frame_t f;
    @(negedge clk);
    o_v = bus.outValid; o_d = bus.outData; o_i = bus.outBinIndex;
    o_f = bus.outFirst; o_l = bus.outLast; o_bf = bus.bufferFull;
    o_drop = bus.framesDropped;
    rel = 1'b0;
    if (reset) begin
      q.delete();
      mdrop = 0; mbin = 0; mprev = 1'b0;
    end else begin
      chk("bufferFull", o_bf, q.size() == 2);
      chk("framesDropped", o_drop, mdrop);
      if (o_v) begin
        if (q.size() == 0) chk("spuriousValid", o_v, 0);
        else begin
          chk("outData", o_d, q[0][mbin]);
          chk("outBinIndex", o_i, mbin);
          chk("outFirst", o_f, mbin == 0);
          chk("outLast", o_l, mbin == BO - 1);
          if (bus.outReady) begin
            n_beats++;
            if (mbin == BO - 1) rel = 1'b1;
            else mbin++;
          end
        end
      end
      cap = bus.OutputValid && !mprev;
      mprev = bus.OutputValid;
      if (rel) begin
        void'(q.pop_front());
        mbin = 0;
      end
      if (cap) begin
        if (q.size() < 2) begin
          for (int i = 0; i < BO; i++) f[i] = bus.SFFT_Out[i];
          q.push_back(f);
        end else if (mdrop < 65535) mdrop++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic pulse(input int base);
    load_frame(base);
    bus.OutputValid = 1'b1;
    step();
    bus.OutputValid = 1'b0;
  endtask

  initial begin
    mdrop = 0; mbin = 0; mprev = 1'b0; n_beats = 0;
    reset = 1'b1;
    bus.OutputValid = 1'b0;
    bus.outReady = 1'b1;
    load_frame(0);
    steps(2);
    reset = 1'b0;
    step();
    chk("rst_outValid", o_v, 0);
    chk("rst_outFirst", o_f, 0);
    chk("rst_outLast", o_l, 0);
    chk("rst_outData", o_d, 0);
    chk("rst_outBinIndex", o_i, 0);
    chk("rst_framesDropped", o_drop, 0);
    chk("rst_bufferFull", o_bf, 0);

    // single pulse: first beat two cycles after the capture cycle
    b0 = n_beats;
    pulse(10);
    step(); chk("lat_T1_valid", o_v, 0);
    step(); chk("lat_T2_valid", o_v, 1); chk("lat_T2_data", o_d, 10); chk("lat_T2_first", o_f, 1);
    step(); step();
    step(); chk("lat_T5_last", o_l, 1); chk("lat_T5_data", o_d, 13);
    step(); chk("lat_T6_valid", o_v, 0);
    chk("single_beats", n_beats - b0, 4);

    // level held high captures once
    b0 = n_beats;
    load_frame(20);
    bus.OutputValid = 1'b1;
    steps(3);
    bus.OutputValid = 1'b0;
    steps(8);
    chk("held_beats", n_beats - b0, 4);
    chk("held_drops", o_drop, 0);

    // stall on the first beat
    pulse(10);
    step();
    bus.outReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_valid", o_v, 1);
      chk("stall_data", o_d, 10);
    end
    bus.outReady = 1'b1;
    b0 = n_beats;
    steps(6);
    chk("stall_beats", n_beats - b0, 4);

    // overflow: A, B buffered, C dropped, then C' after drain
    bus.outReady = 1'b0;
    pulse(100); steps(19);
    pulse(200); steps(19);
    pulse(300); steps(19);
    chk("ovf_bufferFull", o_bf, 1);
    chk("ovf_drops", o_drop, 1);
    b0 = n_beats;
    bus.outReady = 1'b1;
    steps(15);
    chk("ovf_drain_beats", n_beats - b0, 8);
    b0 = n_beats;
    pulse(400); steps(10);
    chk("ovf_cprime_beats", n_beats - b0, 4);

    // capture on the same cycle as the releasing last beat
    bus.outReady = 1'b0;
    pulse(500); steps(3);
    pulse(600); steps(3);
    bus.outReady = 1'b1;
    b0 = n_beats;
    steps(3);
    load_frame(700);
    bus.OutputValid = 1'b1;
    step();
    bus.OutputValid = 1'b0;
    chk("same_last", o_l, 1);
    chk("same_last_data", o_d, 503);
    steps(15);
    chk("same_beats", n_beats - b0, 12);
    chk("same_drops", o_drop, 1);

    // reset mid-stream with the other bank full
    bus.outReady = 1'b0;
    pulse(800); steps(2);
    pulse(900); steps(3);
    bus.outReady = 1'b1;
    steps(2);
    chk("pre_rst_bin", o_i, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("post_rst_valid", o_v, 0);
    chk("post_rst_drops", o_drop, 0);
    chk("post_rst_full", o_bf, 0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("post_rst_quiet", o_v, 0);
    end
    b0 = n_beats;
    pulse(1000);
    step();
    step(); chk("post_rst_first", o_f, 1); chk("post_rst_data", o_d, 1000);
    steps(6);
    chk("post_rst_beats", n_beats - b0, 4);

    // random traffic
    for (int k = 0; k < 1500; k++) begin
      bus.outReady = ($urandom_range(0, 3) != 0);
      bus.OutputValid = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < NFFT; i++) bus.SFFT_Out[i] = $urandom;
      step();
    end
    bus.OutputValid = 1'b0;
    bus.outReady = 1'b1;
    steps(30);
    chk("final_valid", o_v, 0);
    chk("final_full", o_bf, 0);
    chk("final_queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
